// File: rtl/divider_6_bit.sv
// Loadable 6-bit down-counter: divide-by-(N+1) stage with borrow-out and glitch-free divisor reload.
// Optional square-wave output enabled by defining DIVIDER_6_BIT_CLK_OUT_EN.
module divider_6_bit #(
    parameter logic [5:0] RESET_DIV = 6'd63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic       load,
    input  logic [5:0] div_in,
    output logic [5:0] out,
    output logic       next,
`ifdef DIVIDER_6_BIT_CLK_OUT_EN
    output logic       clk_out,
`endif
    output logic       load_ack
);

    logic [5:0] out_q, out_d;
    logic [5:0] div_q, div_d;
    logic [5:0] pend_val_q, pend_val_d;
    logic       pend_q, pend_d;
    logic       ack_q, ack_d;
    logic       terminal;

    assign terminal = count && (out_q == 6'd0);

    always_comb begin
        out_d      = out_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        if (count) begin
            if (terminal) begin
                // A staged divisor is only ever adopted at a terminal count.
                out_d = pend_q ? pend_val_q : div_q;
                if (pend_q) begin
                    div_d  = pend_val_q;
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end else begin
                out_d = out_q - 6'd1;
            end
        end
        // A load in the terminal cycle re-arms pend for the following terminal.
        if (load) begin
            pend_val_d = div_in;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= RESET_DIV;
            div_q      <= RESET_DIV;
            pend_val_q <= 6'd0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
        end
    end

`ifdef DIVIDER_6_BIT_CLK_OUT_EN
    logic clk_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_out_q <= 1'b0;
        end else if (terminal) begin
            clk_out_q <= ~clk_out_q;
        end
    end

    assign clk_out = clk_out_q;
`endif

    assign out      = out_q;
    assign next     = terminal;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_divider_6_bit.sv
// Directed bench for divider_6_bit with a reference model feeding an expected-value queue.
// Exercises the clk_out path too when DIVIDER_6_BIT_CLK_OUT_EN is defined.
module tb_divider_6_bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       count;
    logic       load;
    logic [5:0] div_in;
    logic [5:0] out;
    logic       next;
    logic       load_ack;
`ifdef DIVIDER_6_BIT_CLK_OUT_EN
    logic       clk_out;
`endif

    divider_6_bit #(.RESET_DIV(6'd63)) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .load     (load),
        .div_in   (div_in),
        .out      (out),
        .next     (next),
`ifdef DIVIDER_6_BIT_CLK_OUT_EN
        .clk_out  (clk_out),
`endif
        .load_ack (load_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] o;
        logic       n;
        logic       a;
        logic       c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [5:0] m_out, m_div, m_pv;
    logic       m_pend, m_ack, m_clk;

    // last sampled DUT outputs
    logic [5:0] s_out;
    logic       s_next, s_ack, s_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = 6'd63;
        m_div  = 6'd63;
        m_pv   = 6'd0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
        m_clk  = 1'b0;
    endtask

    task automatic step(input logic c, input logic l, input logic [5:0] d);
        exp_t e;
        exp_t got;
        logic was_pend;
        count  = c;
        load   = l;
        div_in = d;
        e.o = m_out;
        e.n = c && (m_out == 6'd0);
        e.a = m_ack;
        e.c = m_clk;
        q.push_back(e);
        @(negedge clk);
        got    = q.pop_front();
        s_out  = out;
        s_next = next;
        s_ack  = load_ack;
        chk("out", {2'b00, out}, {2'b00, got.o});
        chk("next", {7'd0, next}, {7'd0, got.n});
        chk("load_ack", {7'd0, load_ack}, {7'd0, got.a});
`ifdef DIVIDER_6_BIT_CLK_OUT_EN
        s_clk = clk_out;
        chk("clk_out", {7'd0, clk_out}, {7'd0, got.c});
`else
        s_clk = 1'b0;
`endif
        @(posedge clk);
        was_pend = m_pend;
        m_ack = 1'b0;
        if (c) begin
            if (m_out != 6'd0) begin
                m_out = m_out - 6'd1;
            end else begin
                m_clk = ~m_clk;
                if (was_pend) begin
                    m_div  = m_pv;
                    m_out  = m_pv;
                    m_pend = 1'b0;
                    m_ack  = 1'b1;
                end else begin
                    m_out = m_div;
                end
            end
        end
        if (l) begin
            m_pv   = d;
            m_pend = 1'b1;
        end
        #1;
    endtask

    initial begin
        int n;
        int pulses;
        int hi;
        int lo;
        reset  = 1'b1;
        count  = 1'b0;
        load   = 1'b0;
        div_in = 6'd0;
        model_reset();
        #1;
        chk("reset_out", {2'b00, out}, 8'd63);
        chk("reset_next", {7'd0, next}, 8'd0);
        chk("reset_ack", {7'd0, load_ack}, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // free-running divide-by-64
        pulses = 0;
        for (int i = 0; i < 130; i++) begin
            step(1'b1, 1'b0, 6'd0);
            if (s_next) pulses++;
            if (s_next) chk("next_at_zero", {2'b00, s_out}, 8'd0);
        end
        chk("pulses_64", pulses[7:0], 8'd2);

        // stage 5 mid-period at out=20
        n = 0;
        while (m_out != 6'd20 && n < 100) begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end
        chk("reach_20_timeout", {7'd0, n < 100}, 8'd1);
        step(1'b1, 1'b1, 6'd5);
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end while (!s_next && n < 100);
        chk("old_period_rest", n[7:0], 8'd20);
        chk("adopt5_ack", {7'd0, load_ack}, 8'd1);
        chk("adopt5_out", {2'b00, out}, 8'd5);
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end while (!s_next && n < 100);
        chk("period_6", n[7:0], 8'd6);
        chk("no_reack", {7'd0, load_ack}, 8'd0);

        // divide-by-1
        step(1'b1, 1'b1, 6'd0);
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end while (!s_next && n < 100);
        chk("adopt0_ack", {7'd0, load_ack}, 8'd1);
        chk("adopt0_out", {2'b00, out}, 8'd0);
        step(1'b1, 1'b0, 6'd0);
        chk("div1_next_a", {7'd0, s_next}, 8'd1);
        step(1'b0, 1'b0, 6'd0);
        chk("div1_next_b", {7'd0, s_next}, 8'd0);
        step(1'b1, 1'b0, 6'd0);
        chk("div1_next_c", {7'd0, s_next}, 8'd1);
        chk("div1_out", {2'b00, out}, 8'd0);

        // load in the terminal cycle with nothing pending
        step(1'b1, 1'b1, 6'd3);
        chk("term_load_out", {2'b00, out}, 8'd0);
        chk("term_load_ack", {7'd0, load_ack}, 8'd0);
        step(1'b1, 1'b0, 6'd0);
        chk("term_adopt_out", {2'b00, out}, 8'd3);
        chk("term_adopt_ack", {7'd0, load_ack}, 8'd1);

        // last write wins
        step(1'b1, 1'b1, 6'd7);
        step(1'b1, 1'b1, 6'd2);
        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b0, 6'd0);
        chk("lww_out", {2'b00, out}, 8'd2);
        chk("lww_ack", {7'd0, load_ack}, 8'd1);

        // async reset discards a staged load
        step(1'b1, 1'b1, 6'd9);
        step(1'b1, 1'b0, 6'd0);
        count = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_out", {2'b00, out}, 8'd63);
        chk("mid_reset_ack", {7'd0, load_ack}, 8'd0);
        chk("mid_reset_pend", {7'd0, dut.pend_q}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end while (!s_next && n < 100);
        chk("post_reset_period", n[7:0], 8'd64);
        chk("post_reset_reload", {2'b00, out}, 8'd63);
        chk("post_reset_noack", {7'd0, load_ack}, 8'd0);

`ifdef DIVIDER_6_BIT_CLK_OUT_EN
        step(1'b1, 1'b1, 6'd4);
        n = 0;
        do begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end while (!s_ack && n < 100);
        chk("adopt4_timeout", {7'd0, n < 100}, 8'd1);
        n = 0;
        while (!(s_clk == 1'b0) && n < 40) begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end
        while (s_clk == 1'b0 && n < 40) begin
            step(1'b1, 1'b0, 6'd0);
            n++;
        end
        chk("clk_rise_timeout", {7'd0, n < 40}, 8'd1);
        hi = 1;
        n = 0;
        while (n < 40) begin
            step(1'b1, 1'b0, 6'd0);
            n++;
            if (s_clk) hi++;
            else break;
        end
        chk("clk_out_high", hi[7:0], 8'd5);
        lo = 1;
        step(1'b1, 1'b0, 6'd0);
        if (!s_clk) lo++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 6'd0);
            if (!s_clk) lo++;
        end
        n = 0;
        while (n < 40) begin
            step(1'b1, 1'b0, 6'd0);
            n++;
            if (!s_clk) lo++;
            else break;
        end
        chk("clk_out_low_stretch", lo[7:0], 8'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
